// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll scheduler: die codes, face lookup,
// FSM state encoding and LFSR feedback taps.
package dice_pkg;

  localparam logic [1:0] DIE_D4  = 2'b00;
  localparam logic [1:0] DIE_D6  = 2'b01;
  localparam logic [1:0] DIE_D8  = 2'b10;
  localparam logic [1:0] DIE_D20 = 2'b11;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 in a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  function automatic logic [7:0] die_faces(input logic [1:0] code);
    case (code)
      DIE_D4:  die_faces = 8'd4;
      DIE_D6:  die_faces = 8'd6;
      DIE_D8:  die_faces = 8'd8;
      default: die_faces = 8'd20;
    endcase
  endfunction

endpackage

// File: rtl/dice_rr_arbiter.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping, returned as one-hot plus index.
module dice_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_req      = 1'b0;
    cand         = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IW'((int'(ptr) + off) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req            = 1'b1;
        grant_idx          = ID_W'(cand);
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Round-robin dice roller sharing one LFSR and iterative modulo reducer.
// Optional statistics outputs are enabled by defining DICE_SCHED_STATS_EN.
module dice_roll_scheduler
  import dice_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          ID_W      = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] die_sel,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [7:0]           result_value,
  output logic [ID_W-1:0]      result_id,
  input  logic                 seed_load,
  input  logic [15:0]          seed
`ifdef DICE_SCHED_STATS_EN
  ,
  output logic [15:0]          roll_count,
  output logic [7:0]           max_wait
`endif
);

  state_t state, state_next;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [1:0]         sel_code;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic [7:0]         rem;
  logic [7:0]         faces;
  logic [15:0]        lfsr;
  logic               take_grant;
  logic               reduce_done;
  logic               accept;

  assign take_grant  = (state == ST_IDLE) && arb_any;
  assign reduce_done = (state == ST_REDUCE) && (rem < faces);
  assign accept      = (state == ST_RESULT) && result_ready;
  assign busy        = (state != ST_IDLE);

  dice_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_onehot(arb_onehot),
    .grant_idx   (arb_idx),
    .any_req     (arb_any)
  );

  always_comb begin
    sel_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) sel_code = die_sel[2*i +: 2];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (arb_any)      state_next = ST_REDUCE;
      ST_REDUCE: if (rem < faces)  state_next = ST_RESULT;
      ST_RESULT: if (result_ready) state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // The sample is taken from the pre-update LFSR, so a same-cycle seed load
  // only affects later rolls.
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant        <= '0;
      result_valid <= 1'b0;
      result_value <= '0;
      result_id    <= '0;
      rr_ptr       <= '0;
      lfsr         <= LFSR_SEED;
      rem          <= '0;
      faces        <= '0;
      cur_id       <= '0;
    end else begin
      grant <= take_grant ? arb_onehot : '0;
      if (seed_load)       lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
      else if (take_grant) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      if (take_grant) begin
        rem    <= lfsr[7:0];
        faces  <= die_faces(sel_code);
        cur_id <= arb_idx;
      end else if ((state == ST_REDUCE) && (rem >= faces)) begin
        rem <= rem - faces;
      end
      if (reduce_done) begin
        result_value <= rem + 8'd1;
        result_id    <= cur_id;
        result_valid <= 1'b1;
      end else if (accept) begin
        result_valid <= 1'b0;
        rr_ptr       <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
      end
    end
  end

`ifdef DICE_SCHED_STATS_EN
  logic [7:0] wait_cnt  [NUM_REQ];
  logic [7:0] wait_next [NUM_REQ];
  logic [7:0] wait_max;

  // Per-requester wait counters only advance in IDLE, where arbitration happens
  always_comb begin
    wait_max = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_next[i] = wait_cnt[i];
      if (state == ST_IDLE) begin
        if (!req[i] || arb_onehot[i])  wait_next[i] = '0;
        else if (wait_cnt[i] != 8'hFF) wait_next[i] = wait_cnt[i] + 8'd1;
      end
      if (wait_next[i] > wait_max) wait_max = wait_next[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      roll_count <= '0;
      max_wait   <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      if (accept) roll_count <= roll_count + 16'd1;
      if (wait_max > max_wait) max_wait <= wait_max;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= wait_next[i];
    end
  end
`endif

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Self-checking bench for dice_roll_scheduler using a result scoreboard.
// Statistics checks run only when DICE_SCHED_STATS_EN is defined.
module tb_dice_roll_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  die_sel;
  logic [3:0]  grant;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [7:0]  result_value;
  logic [1:0]  result_id;
  logic        seed_load;
  logic [15:0] seed;
`ifdef DICE_SCHED_STATS_EN
  logic [15:0] roll_count;
  logic [7:0]  max_wait;
`endif

  typedef struct {
    logic [1:0] id;
    logic [7:0] faces;
    logic [7:0] value;
    bit         exact;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dice_roll_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .die_sel     (die_sel),
    .grant       (grant),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_value(result_value),
    .result_id   (result_id),
    .seed_load   (seed_load),
    .seed        (seed)
`ifdef DICE_SCHED_STATS_EN
    ,
    .roll_count  (roll_count),
    .max_wait    (max_wait)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] ds, input logic rdy);
    req          = r;
    die_sel      = ds;
    result_ready = rdy;
  endtask

  task automatic resetDut();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic loadSeed(input logic [15:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic pushExpect(input logic [1:0] id, input logic [7:0] faces, input logic [7:0] value, input bit exact);
    exp_t e;
    e.id    = id;
    e.faces = faces;
    e.value = value;
    e.exact = exact;
    sb.push_back(e);
  endtask

  task automatic waitGrant(input string tag);
    int n = 0;
    while (grant == 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, "_grant_seen"}, 32'(grant != 4'b0000), 1);
  endtask

  task automatic waitResult(input string tag, output int lat);
    lat = 0;
    while (!result_valid && lat < 200) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_valid_seen"}, 32'(result_valid), 1);
  endtask

  task automatic popResult(input string tag);
    exp_t e;
    checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput({tag, "_id"}, 32'(result_id), 32'(e.id));
    if (e.exact) checkOutput({tag, "_value"}, 32'(result_value), 32'(e.value));
    else checkOutput({tag, "_range"}, 32'(result_value >= 8'd1 && result_value <= e.faces), 1);
  endtask

  initial begin
    int  lat;
    bit  saw_result;
    reset        = 1'b0;
    seed_load    = 1'b0;
    seed         = '0;
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst_busy",  32'(busy), 0);
    checkOutput("rst_valid", 32'(result_valid), 0);
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_value", 32'(result_value), 0);
    checkOutput("rst_id",    32'(result_id), 0);
`ifdef DICE_SCHED_STATS_EN
    checkOutput("rst_roll_count", 32'(roll_count), 0);
    checkOutput("rst_max_wait",   32'(max_wait), 0);
`endif
    reset = 1'b1;

    $display("[TB] seed 0x00C8, requester 0 rolls d20");
    loadSeed(16'h00C8);
    applyStimulus(4'b0001, 8'b00_00_00_11, 1'b0);
    pushExpect(2'd0, 8'd20, 8'd1, 1'b1);
    tick();
    checkOutput("t1_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    checkOutput("t1_grant_pulse", 32'(grant), 0);
    waitResult("t1", lat);
    checkOutput("t1_latency", 32'(lat + 1), 11);
    popResult("t1");
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checkOutput("t1_valid_clr", 32'(result_valid), 0);
    checkOutput("t1_busy_clr",  32'(busy), 0);

    $display("[TB] seed 0x0007, requester 2 rolls d6 with held backpressure");
    loadSeed(16'h0007);
    applyStimulus(4'b0100, 8'b00_01_00_00, 1'b0);
    pushExpect(2'd2, 8'd6, 8'd2, 1'b1);
    tick();
    checkOutput("t2_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    waitResult("t2", lat);
    checkOutput("t2_latency", 32'(lat), 2);
    popResult("t2");
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("t2_hold_valid", 32'(result_valid), 1);
      checkOutput("t2_hold_value", 32'(result_value), 2);
      checkOutput("t2_hold_id",    32'(result_id), 2);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checkOutput("t2_valid_clr", 32'(result_valid), 0);
    checkOutput("t2_busy_clr",  32'(busy), 0);

    $display("[TB] round-robin over four continuous requesters");
    resetDut();
    applyStimulus(4'b1111, 8'b11_10_01_00, 1'b1);
    for (int r = 0; r < 8; r++) begin
      logic [7:0] f;
      f = (r % 4 == 0) ? 8'd4 : (r % 4 == 1) ? 8'd6 : (r % 4 == 2) ? 8'd8 : 8'd20;
      waitGrant("t3");
      checkOutput("t3_grant_order", 32'(grant), 32'(1 << (r % 4)));
      pushExpect(2'(r % 4), f, 8'd0, 1'b0);
      waitResult("t3", lat);
      popResult("t3");
      if (r == 7) req = 4'b0000;
      tick();
    end
    result_ready = 1'b0;

    $display("[TB] zero seed maps to 0x0001, d8 roll");
    loadSeed(16'h0000);
    applyStimulus(4'b0001, 8'b00_00_00_10, 1'b0);
    pushExpect(2'd0, 8'd8, 8'd2, 1'b1);
    tick();
    checkOutput("t4_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    waitResult("t4", lat);
    checkOutput("t4_latency", 32'(lat), 1);
    popResult("t4");
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    $display("[TB] reset during a long reduction");
    loadSeed(16'h00C8);
    applyStimulus(4'b0010, 8'b00_00_11_00, 1'b0);
    tick();
    checkOutput("t5_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    tick();
    tick();
    checkOutput("t5_busy_mid", 32'(busy), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("t5_busy_after_rst",  32'(busy), 0);
    checkOutput("t5_valid_after_rst", 32'(result_valid), 0);
    saw_result = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (result_valid) saw_result = 1'b1;
    end
    checkOutput("t5_no_result", 32'(saw_result), 0);
    applyStimulus(4'b1111, 8'h00, 1'b0);
    tick();
    checkOutput("t5_grant_req0", 32'(grant), 32'h1);
    req = 4'b0000;
    resetDut();

`ifdef DICE_SCHED_STATS_EN
    $display("[TB] statistics: three rolls with requester 3 waiting");
    applyStimulus(4'b1011, 8'h00, 1'b1);
    for (int r = 0; r < 3; r++) begin
      waitGrant("t6");
      pushExpect((r == 2) ? 2'd3 : 2'(r), 8'd4, 8'd0, 1'b0);
      waitResult("t6", lat);
      popResult("t6");
      if (r == 2) req = 4'b0000;
      tick();
    end
    result_ready = 1'b0;
    checkOutput("t6_roll_count", 32'(roll_count), 3);
    checkOutput("t6_max_wait_nonzero", 32'(max_wait != 8'd0), 1);
`endif

    checkOutput("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dice_roll_scheduler.md
Name: dice_roll_scheduler

Overview:
- Shares one dice-roll datapath between NUM_REQ requesters (players), granting them in round-robin order.
- The datapath is a 16-bit LFSR plus an iterative modulo reducer.
- Each granted request takes one LFSR sample, reduces it to the selected die (d4/d6/d8/d20) and returns a 1-based face value with the requester ID over a valid/ready result handshake.
- Sits between the player-input logic and the score/display logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, result ID width; must satisfy 2**ID_W >= NUM_REQ.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester roll request; held high until granted.
- die_sel  in  2*NUM_REQ  per-requester die code, slice i = [2i+1:2i]; 00=d4, 01=d6, 10=d8, 11=d20.
- grant  out  NUM_REQ  one-hot, one-cycle pulse marking the accepted request.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_value  out  8  face value, 1..faces.
- result_id  out  ID_W  index of the requester that was served.
- seed_load  in  1  load the LFSR from seed.
- seed  in  16  seed value.

Behaviour:
- Reset (clock edge with reset=0): state=IDLE, grant=0, busy=0, result_valid=0, result_value=0, result_id=0, rr pointer=0, lfsr=LFSR_SEED. Reset takes effect in any state and aborts any in-flight roll with no result.
- LFSR: Fibonacci form, polynomial x^16+x^14+x^13+x^11+1. It advances exactly once per grant and holds otherwise.
- seed_load=1 loads the LFSR on the next edge. A seed of 0 loads 16'h0001. seed_load has priority over a same-cycle advance; the sample taken in that cycle still uses the pre-load LFSR value. seed_load never disturbs an in-flight roll.
- FSM states are IDLE, REDUCE, RESULT.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from the rr pointer, wrapping.
  - Next edge: grant[i]=1 for exactly one cycle; capture rem=lfsr[7:0], faces from die_sel slice i, and id=i; go to REDUCE.
  - If no req bit is set, stay in IDLE.
- REDUCE:
  - Each cycle, if rem >= faces then rem <= rem - faces.
  - Otherwise result_value <= rem + 1, result_id <= id, result_valid <= 1, and go to RESULT.
  - Latency from grant pulse to result_valid = floor(sample/faces) + 1 cycles. Worst case is 64 cycles (sample 255, d4).
- RESULT:
  - Hold result_valid, result_value and result_id stable until result_ready=1.
  - On the accept edge: result_valid <= 0, rr pointer <= (id+1) mod NUM_REQ, go to IDLE. result_value and result_id keep their last values.
  - The earliest next grant is one cycle after returning to IDLE; there is no back-to-back grant.
- req and die_sel are ignored outside IDLE; die_sel is sampled only at the grant edge.
- If a requester drops req before it is granted, it is simply skipped.
- result_ready while result_valid=0 has no effect.
- All arithmetic is unsigned 8-bit. faces is one of 4, 6, 8, 20, so rem never underflows.

Optional Feature:
- Macro DICE_SCHED_STATS_EN.
- When defined:
  - Adds output roll_count (16 bits), incremented on each result accept edge and wrapping at 16'hFFFF to 0.
  - Adds output max_wait (8 bits), the largest count of IDLE cycles any req bit stayed high ungranted, saturating at 255.
  - Both are cleared by reset.
- When undefined, these ports and their logic are absent and the rest of the behaviour is identical.

Decomposition:
- Package dice_pkg holds:
  - die code localparams (DIE_D4=2'b00, DIE_D6=2'b01, DIE_D8=2'b10, DIE_D20=2'b11);
  - faces lookup function (code to 4, 6, 8, 20);
  - FSM state encoding;
  - LFSR tap mask 16'hB400.
- One sub-module, dice_rr_arbiter: purely combinational round-robin select (req, pointer to one-hot plus index), reusable elsewhere.
- The LFSR and reducer stay inline.

Test Plan:
- Reset, then seed_load with seed=16'h00C8; req=4'b0001, die_sel[1:0]=11 → grant=0001 for one cycle; result_valid 11 cycles after the grant pulse; result_value=1, result_id=0.
- Seed 16'h0007; requester 2 rolls d6 → result_value=2 two cycles after grant; hold result_ready=0 for 5 cycles → outputs stable; accept → result_valid=0 and busy=0 next cycle.
- req=4'b1111 held continuously, any seed, 8 rolls with result_ready tied to 1 → grant order 0,1,2,3,0,1,2,3 and every result_value within 1..faces.
- seed_load with seed=0, then a d8 roll → sample=8'h01, result_value=2.
- Assert reset for one cycle mid-REDUCE → next cycle busy=0, result_valid=0, no result emitted; the next req is granted to requester 0.
- With DICE_SCHED_STATS_EN defined, complete 3 rolls → roll_count=3; with req[3] held through 2 other rolls → max_wait is nonzero.
